// File: rtl/aig_tt_pkg.sv
// Shared types and helpers for the truth-table reader: FSM states and the
// rotate-XOR signature step.
package aig_tt_pkg;

  localparam int SIG_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  // Rotate left by one, then fold in the (already zero-extended) output word.
  function automatic logic [SIG_W-1:0] sig_step(input logic [SIG_W-1:0] s,
                                                input logic [SIG_W-1:0] f);
    return {s[SIG_W-2:0], s[SIG_W-1]} ^ f;
  endfunction

endpackage

// File: rtl/aig_tt_mem.sv
// Truth-table storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; every row is rewritten before it is streamed.
module aig_tt_mem #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 7
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [N_IN-1:0]  i_waddr,
  input  logic [N_OUT-1:0] i_wdata,
  input  logic [N_IN-1:0]  i_raddr,
  output logic [N_OUT-1:0] o_rdata
);

  localparam int ROWS = 1 << N_IN;

  logic [N_OUT-1:0] r_mem [ROWS];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/aig_tt_reader.sv
// Sweeps every input vector of a combinational circuit, captures its outputs
// into a table plus a rotate-XOR signature, then streams the table out.
module aig_tt_reader
  import aig_tt_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 7,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [N_IN-1:0]  x_o,
  input  logic [N_OUT-1:0] f_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] out_data,
  output logic [N_IN-1:0]  out_idx,
  output logic             out_last,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output state_t           dbg_state
);

  localparam logic [N_IN:0] LAST_ROW   = {1'b0, {N_IN{1'b1}}};
  localparam logic [N_IN:0] ROW_ONE    = {{N_IN{1'b0}}, 1'b1};
  localparam logic [3:0]    CNT_RELOAD = 4'(SETTLE - 1);

  state_t           r_state, w_state_nxt;
  logic [N_IN:0]    r_row, w_row_nxt;
  logic [N_IN:0]    r_rd, w_rd_nxt;
  logic [3:0]       r_cnt, w_cnt_nxt;
  logic [SIG_W-1:0] r_sig, w_sig_nxt;
  logic [N_IN-1:0]  r_x, w_x_nxt;
  logic             r_valid, w_valid_nxt;
  logic [N_OUT-1:0] r_data, w_data_nxt;
  logic [N_IN-1:0]  r_idx, w_idx_nxt;
  logic             r_last, w_last_nxt;
  logic             r_done, w_done_nxt;
  logic             r_busy;
  logic             w_we;
  logic             w_xfer;
  logic [N_OUT-1:0] w_rdata;
  logic [SIG_W-1:0] w_f_ext;

  // Handshake: a row moves when out_valid && out_ready at a rising edge; while
  // out_valid is high and out_ready low, out_data/out_idx/out_last hold.
  assign w_xfer  = r_valid & out_ready;
  assign w_f_ext = SIG_W'(f_i);

  aig_tt_mem #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_mem (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (r_row[N_IN-1:0]),
    .i_wdata (f_i),
    .i_raddr (w_rd_nxt[N_IN-1:0]),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_rd_nxt    = r_rd;
    w_cnt_nxt   = r_cnt;
    w_sig_nxt   = r_sig;
    w_we        = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_APPLY;
          w_row_nxt   = '0;
          w_cnt_nxt   = CNT_RELOAD;
          w_sig_nxt   = '0;
        end
      end
      ST_APPLY: begin
        if (r_cnt == 4'd0) begin
          w_we      = 1'b1;
          w_sig_nxt = sig_step(r_sig, w_f_ext);
          w_cnt_nxt = CNT_RELOAD;
          if (r_row == LAST_ROW) begin
            w_state_nxt = ST_STREAM;
            w_row_nxt   = '0;
            w_rd_nxt    = '0;
          end else begin
            w_row_nxt = r_row + ROW_ONE;
          end
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_STREAM: begin
        if (w_xfer) begin
          if (r_rd == LAST_ROW) begin
            w_state_nxt = ST_IDLE;
            w_rd_nxt    = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_rd_nxt = r_rd + ROW_ONE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Output registers are loaded from next-state values so every port is a flop.
    w_x_nxt     = (w_state_nxt == ST_APPLY) ? w_row_nxt[N_IN-1:0] : '0;
    w_valid_nxt = (w_state_nxt == ST_STREAM);
    w_data_nxt  = w_valid_nxt ? w_rdata : '0;
    w_idx_nxt   = w_valid_nxt ? w_rd_nxt[N_IN-1:0] : '0;
    w_last_nxt  = w_valid_nxt && (w_rd_nxt == LAST_ROW);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_row   <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_sig   <= '0;
      r_x     <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_row   <= w_row_nxt;
      r_rd    <= w_rd_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sig   <= w_sig_nxt;
      r_x     <= w_x_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_idx   <= w_idx_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  assign busy      = r_busy;
  assign x_o       = r_x;
  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_idx   = r_idx;
  assign out_last  = r_last;
  assign done      = r_done;
  assign sig       = r_sig;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_aig_tt_reader.sv
// Directed bench for aig_tt_reader: sweeps with a modelled circuit, scoreboard
// of expected rows, and timing/backpressure/abort/back-to-back checks.
module tb_aig_tt_reader;
  import aig_tt_pkg::*;

  localparam int N_IN  = 3;
  localparam int N_OUT = 7;
  localparam int ROWS  = 8;
  localparam int W     = N_IN + N_OUT + 1;

  // clock / reset / signals
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, start, out_ready;
  logic             busy, out_valid, out_last, done;
  logic [N_IN-1:0]  x_o, out_idx;
  logic [N_OUT-1:0] f_i, out_data;
  logic [15:0]      sig;
  state_t           dbg_state;

  logic             start3, ready3;
  logic             busy3, valid3, last3, done3;
  logic [N_IN-1:0]  x3, idx3;
  logic [N_OUT-1:0] f3, data3;
  logic [15:0]      sig3;
  state_t           dbg3;

  int mode;
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  function automatic logic [N_OUT-1:0] f_model(input int m, input logic [N_IN-1:0] x);
    case (m)
      0:       return {4'b0000, x};
      1:       return 7'h7F;
      default: return {x[0], x, ~x} ^ 7'h15;
    endcase
  endfunction

  function automatic logic [N_OUT-1:0] f3_model(input logic [N_IN-1:0] x);
    return {x, ~x, x[0]};
  endfunction

  always_comb f_i = f_model(mode, x_o);
  always_comb f3  = f3_model(x3);

  aig_tt_reader #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(1)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .x_o(x_o), .f_i(f_i),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .done(done), .sig(sig),
    .dbg_state(dbg_state)
  );

  aig_tt_reader #(.N_IN(N_IN), .N_OUT(N_OUT), .SETTLE(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .busy(busy3), .x_o(x3), .f_i(f3),
    .out_valid(valid3), .out_ready(ready3), .out_data(data3),
    .out_idx(idx3), .out_last(last3), .done(done3), .sig(sig3),
    .dbg_state(dbg3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_sig(input int m);
    logic [15:0] s = '0;
    for (int r = 0; r < ROWS; r++) s = {s[14:0], s[15]} ^ {9'b0, f_model(m, 3'(r))};
    return s;
  endfunction

  task automatic push_rows(input int m);
    for (int r = 0; r < ROWS; r++)
      exp_q.push_back({3'(r), f_model(m, 3'(r)), (r == ROWS - 1)});
  endtask

  // driver: one full sweep on the SETTLE=1 instance, returns in the done cycle
  task automatic run_sweep(input int m, input logic [15:0] sig_exp, input bit start_now,
                           input int stall_idx, input bit poke_start);
    int cyc, guard, stall_left;
    bit held_valid, last_seen;
    logic [W-1:0] held, got, exp;
    mode = m;
    push_rows(m);
    if (!start_now) @(negedge clk);
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_after_start", busy, 1);
    check("sig_cleared", sig, 0);
    while (!out_valid && cyc < 40) begin
      if (cyc <= ROWS) check("x_o_apply", x_o, cyc - 1);
      @(negedge clk);
      cyc++;
    end
    check("first_valid_cycle", cyc, ROWS + 1);
    stall_left = 5;
    held_valid = 1'b0;
    last_seen  = 1'b0;
    held = '0;
    guard = 0;
    while (!last_seen && guard < 60) begin
      guard++;
      check("done_early", done, 0);
      if (held_valid) check("stall_stable", {out_idx, out_data, out_last}, held);
      if (poke_start) start = out_valid && (out_idx == 3'd3);
      if (out_valid && int'(out_idx) == stall_idx && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        held = {out_idx, out_data, out_last};
        held_valid = 1'b1;
      end else begin
        out_ready = 1'b1;
        held_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        got = {out_idx, out_data, out_last};
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("row", got, exp);
        if (got[0]) last_seen = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_pulse", done, 1);
    check("sig_final", sig, sig_exp);
    check("busy_idle", busy, 0);
    check("valid_low", out_valid, 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s3;
    logic [W-1:0] got, exp;
    int guard;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0; start3 = 1'b0; ready3 = 1'b0; mode = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_x_o", x_o, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_done", done, 0);
    check("rst_sig", sig, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;

    // loopback, then the done pulse must drop after one cycle
    run_sweep(0, 16'h000F, 1'b0, -1, 1'b0);
    @(negedge clk);
    check("done_one_cycle", done, 0);

    // constant circuit with backpressure at row 2
    run_sweep(1, 16'h2AD5, 1'b0, 2, 1'b0);

    // abort at APPLY row 4
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (x_o != 3'd4 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("abort_at_row4", x_o, 4);
    check("abort_sig_partial_nonzero", (sig != 16'h0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_sig", sig, 0);
    check("abort_done", done, 0);
    check("abort_valid", out_valid, 0);
    check("abort_state", dbg_state, ST_IDLE);
    @(negedge clk);
    check("abort_no_done", done, 0);

    // full sweep after abort, start pulses during STREAM ignored
    run_sweep(2, model_sig(2), 1'b0, -1, 1'b1);

    // back-to-back: second start in the done cycle
    run_sweep(0, 16'h000F, 1'b0, -1, 1'b0);
    run_sweep(1, 16'h2AD5, 1'b1, -1, 1'b0);

    // SETTLE=3 instance
    s3 = '0;
    for (int r = 0; r < ROWS; r++) begin
      exp_q.push_back({3'(r), f3_model(3'(r)), (r == ROWS - 1)});
      s3 = {s3[14:0], s3[15]} ^ {9'b0, f3_model(3'(r))};
    end
    @(negedge clk);
    start3 = 1'b1;
    ready3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int c = 1; c <= 3 * ROWS; c++) begin
      check("s3_x_hold", x3, (c - 1) / 3);
      check("s3_valid_low", valid3, 0);
      @(negedge clk);
    end
    for (int i = 0; i < ROWS; i++) begin
      check("s3_valid", valid3, 1);
      got = {idx3, data3, last3};
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      check("s3_row", got, exp);
      @(negedge clk);
    end
    check("s3_done", done3, 1);
    check("s3_sig", sig3, s3);
    check("s3_busy", busy3, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
